// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman ioctl download loader.
package pacman_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROM  = 3'd1,
    MOD  = 3'd2,
    DIP  = 3'd3,
    SKIP = 3'd4,
    HOLD = 3'd5
  } loader_state_t;

  // hps_io download target indices
  localparam logic [7:0] ROM_IDX     = 8'd0;
  localparam logic [7:0] MOD_IDX_DEF = 8'd1;
  localparam logic [7:0] DIP_IDX_DEF = 8'd254;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned SW_BYTES     = 8;

  // True when a byte address fits in a window of 2**width bytes
  function automatic logic addr_fits(input logic [IOCTL_ADDR_W-1:0] addr,
                                     input int unsigned width);
    logic [IOCTL_ADDR_W-1:0] upper;
    upper = '0;
    if (width >= IOCTL_ADDR_W) begin
      return 1'b1;
    end
    upper = addr >> width;
    return (upper == '0);
  endfunction

endpackage

// File: rtl/pacman_rom_loader_reset_stretcher.sv
// Load/count-down counter: busy while the count is non-zero. Reset loads
// the full count so the same counter also provides the post-reset hold.
module reset_stretcher #(
  parameter int unsigned COUNT = 32
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic busy,
  output logic last
);

  localparam int unsigned CW = $clog2(COUNT + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Next count: load wins over clear, otherwise decrement towards zero
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = CW'(COUNT);
    end else if (clear) begin
      count_next = '0;
    end else if (count_reg != '0) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Counter register, full count out of reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_reg <= CW'(COUNT);
    end else begin
      count_reg <= count_next;
    end
  end

  assign busy = (count_reg != '0);
  // Final busy cycle; the owner uses it to leave its hold state in step
  assign last = (count_reg == CW'(1));

endmodule

// File: rtl/pacman_rom_loader.sv
// Steers the hps_io ioctl download stream: ROM bytes to the core's dn_* port,
// the variant byte to mod_id, switch bytes to sw, and keeps the core in reset
// while the ROM loads and for RST_HOLD cycles afterwards.
module pacman_rom_loader
  import pacman_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RST_HOLD = 32,
  parameter logic [7:0]  MOD_IDX  = MOD_IDX_DEF,
  parameter logic [7:0]  DIP_IDX  = DIP_IDX_DEF
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic [ADDR_W-1:0]       dn_addr,
  output logic [7:0]              dn_data,
  output logic                    dn_wr,
  output logic [7:0]              mod_id,
  output logic [63:0]             sw,
  output logic                    core_reset,
  output logic                    rom_loaded,
  output logic                    addr_overflow
);

  loader_state_t state_reg;
  loader_state_t state_next;

  logic              dl_prev_reg;
  logic              post_reset_reg;
  logic              any_byte_reg;
  logic              rom_loaded_reg;
  logic              overflow_reg;
  logic              dn_wr_reg;
  logic [ADDR_W-1:0] dn_addr_reg;
  logic [7:0]        dn_data_reg;
  logic [7:0]        mod_id_reg;

  logic dl_rise;
  logic in_range;
  logic rom_accept;
  logic rom_drop;
  logic rom_done;
  logic mod_wr;
  logic dip_wr;
  logic rom_start;
  logic hold_load;
  logic hold_clear;
  logic hold_busy;
  logic hold_last;

  assign dl_rise  = ioctl_download & ~dl_prev_reg;
  assign in_range = addr_fits(ioctl_addr, ADDR_W);

  // Byte handling depends only on the state, not on the download level, so a
  // strobe coinciding with the falling edge is still taken.
  assign rom_accept = (state_reg == ROM) && ioctl_wr && in_range;
  assign rom_drop   = (state_reg == ROM) && ioctl_wr && !in_range;
  assign rom_done   = (state_reg == ROM) && !ioctl_download;
  assign mod_wr     = (state_reg == MOD) && ioctl_wr && (ioctl_addr == '0);
  assign dip_wr     = (state_reg == DIP) && ioctl_wr && (ioctl_addr[IOCTL_ADDR_W-1:3] == '0);

  // Next-state logic; the index is only looked at on the download rising edge
  always_comb begin
    state_next = state_reg;
    rom_start  = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state_reg)
      IDLE, HOLD: begin
        if (dl_rise) begin
          // Leaving HOLD early drops the remaining hold time
          hold_clear = (state_reg == HOLD);
          if (post_reset_reg) begin
            // Edge seen right after reset is a download already in flight
            state_next = SKIP;
          end else if (ioctl_index == ROM_IDX) begin
            state_next = ROM;
            rom_start  = 1'b1;
          end else if (ioctl_index == MOD_IDX) begin
            state_next = MOD;
          end else if (ioctl_index == DIP_IDX) begin
            state_next = DIP;
          end else begin
            state_next = SKIP;
          end
        end else if ((state_reg == HOLD) && hold_last) begin
          state_next = IDLE;
        end
      end
      ROM: begin
        if (!ioctl_download) begin
          state_next = HOLD;
          hold_load  = 1'b1;
        end
      end
      MOD, DIP, SKIP: begin
        if (!ioctl_download) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, download edge detector and post-reset marker
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= IDLE;
      dl_prev_reg    <= 1'b0;
      post_reset_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      dl_prev_reg    <= ioctl_download;
      post_reset_reg <= 1'b0;
    end
  end

  // ROM write port towards the core: one-cycle strobe, address/data hold
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_wr_reg   <= 1'b0;
      dn_addr_reg <= '0;
      dn_data_reg <= '0;
    end else begin
      dn_wr_reg <= rom_accept;
      if (rom_accept) begin
        dn_addr_reg <= ioctl_addr[ADDR_W-1:0];
        dn_data_reg <= ioctl_dout;
      end
    end
  end

  // Sticky status: bytes accepted this download, ROM loaded, address overflow
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      any_byte_reg   <= 1'b0;
      rom_loaded_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (rom_start) begin
        any_byte_reg <= 1'b0;
      end else if (rom_accept) begin
        any_byte_reg <= 1'b1;
      end
      if (rom_start) begin
        rom_loaded_reg <= 1'b0;
      end else if (rom_done && (any_byte_reg || rom_accept)) begin
        rom_loaded_reg <= 1'b1;
      end
      if (rom_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Game variant byte
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mod_id_reg <= '0;
    end else if (mod_wr) begin
      mod_id_reg <= ioctl_dout;
    end
  end

  // One register per switch byte, selected by the low address bits
  for (genvar gi = 0; gi < SW_BYTES; gi++) begin : g_sw
    logic [7:0] byte_reg;

    // Switch byte gi, all ones out of reset
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        byte_reg <= 8'hFF;
      end else if (dip_wr && (ioctl_addr[2:0] == 3'(gi))) begin
        byte_reg <= ioctl_dout;
      end
    end

    assign sw[8*gi +: 8] = byte_reg;
  end

  // Shared counter: post-reset hold, then reloaded on every ROM->HOLD entry
  reset_stretcher #(
    .COUNT (RST_HOLD)
  ) u_hold (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (hold_load),
    .clear   (hold_clear),
    .busy    (hold_busy),
    .last    (hold_last)
  );

  assign core_reset    = (state_reg == ROM) || (state_reg == HOLD) || hold_busy;
  assign dn_wr         = dn_wr_reg;
  assign dn_addr       = dn_addr_reg;
  assign dn_data       = dn_data_reg;
  assign mod_id        = mod_id_reg;
  assign rom_loaded    = rom_loaded_reg;
  assign addr_overflow = overflow_reg;

endmodule

// File: tb/tb_pacman_rom_loader.sv
// Directed bench for pacman_rom_loader: reset hold, ROM routing and latency,
// address overflow, switch/mod capture, and reset in the middle of a download.
module tb_pacman_rom_loader;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned RST_HOLD = 32;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [7:0]        mod_id;
  logic [63:0]       sw;
  logic              core_reset;
  logic              rom_loaded;
  logic              addr_overflow;

  int total = 0;
  int bad = 0;
  int dn_wr_count = 0;

  pacman_rom_loader #(
    .ADDR_W   (ADDR_W),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .mod_id         (mod_id),
    .sw             (sw),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .addr_overflow  (addr_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Count every dn_wr pulse the DUT emits, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) dn_wr_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One ioctl byte strobe; outputs are sampled 1 ns after the accepting edge
  task automatic byte_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    $display("wr idx=%0d addr=%h data=%h -> dn_wr=%b dn_addr=%h dn_data=%h",
             ioctl_index, a, d, dn_wr, dn_addr, dn_data);
  endtask

  // Number of consecutive samples with core_reset high, bounded
  task automatic count_reset_high(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] d;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;

    // 1. Reset for 3 cycles, then the post-reset hold
    repeat (3) step();
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_dn_wr", 64'(dn_wr), 64'd0);
    check("rst_dn_addr", 64'(dn_addr), 64'd0);
    check("rst_dn_data", 64'(dn_data), 64'd0);
    check("rst_mod_id", 64'(mod_id), 64'd0);
    check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("rst_overflow", 64'(addr_overflow), 64'd0);
    reset = 1'b0;
    count_reset_high(n);
    check("rst_hold_len", 64'(n), 64'd32);
    check("rst_no_dn_wr", 64'(dn_wr_count), 64'd0);

    // 2. ROM download: two bytes, one-cycle latency, hold afterwards
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    check("rom_core_reset", 64'(core_reset), 64'd1);
    byte_wr(25'h0_0000, 8'h3E);
    check("rom0_dn_wr", 64'(dn_wr), 64'd1);
    check("rom0_dn_addr", 64'(dn_addr), 64'h0000);
    check("rom0_dn_data", 64'(dn_data), 64'h3E);
    step();
    check("rom0_dn_wr_off", 64'(dn_wr), 64'd0);
    check("rom0_data_hold", 64'(dn_data), 64'h3E);
    byte_wr(25'h0_FFFF, 8'hC3);
    check("rom1_dn_wr", 64'(dn_wr), 64'd1);
    check("rom1_dn_addr", 64'(dn_addr), 64'hFFFF);
    check("rom1_dn_data", 64'(dn_data), 64'hC3);
    step();
    check("rom_core_reset_mid", 64'(core_reset), 64'd1);
    check("rom_loaded_mid", 64'(rom_loaded), 64'd0);
    ioctl_download = 1'b0;
    step();
    count_reset_high(n);
    check("rom_hold_len", 64'(n), 64'd32);
    check("rom_loaded", 64'(rom_loaded), 64'd1);
    check("rom_dn_wr_count", 64'(dn_wr_count), 64'd2);

    // 3. Out-of-range ROM byte
    ioctl_download = 1'b1;
    step();
    check("ovf_loaded_clr", 64'(rom_loaded), 64'd0);
    byte_wr(25'h1_0000, 8'h55);
    check("ovf_dn_wr", 64'(dn_wr), 64'd0);
    check("ovf_flag", 64'(addr_overflow), 64'd1);
    check("ovf_addr_hold", 64'(dn_addr), 64'hFFFF);
    ioctl_download = 1'b0;
    step();
    count_reset_high(n);
    check("ovf_hold_len", 64'(n), 64'd32);
    check("ovf_loaded", 64'(rom_loaded), 64'd0);
    check("ovf_sticky", 64'(addr_overflow), 64'd1);

    // 4. Switch bytes at index 254; address 8 is out of the window
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    step();
    check("dip_core_reset", 64'(core_reset), 64'd0);
    byte_wr(25'd0, 8'h11);
    check("dip_byte0", sw, 64'hFFFF_FFFF_FFFF_FF11);
    for (int i = 1; i < 8; i++) begin
      d = 8'h11 + 8'(i);
      byte_wr(25'(i), d);
    end
    byte_wr(25'd8, 8'hAA);
    check("dip_sw", sw, 64'h1817_1615_1413_1211);
    check("dip_core_reset_end", 64'(core_reset), 64'd0);
    ioctl_download = 1'b0;
    step();
    check("dip_dn_wr_count", 64'(dn_wr_count), 64'd2);

    // 5. Mod byte: only address 0 counts; index changes mid-download ignored
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    step();
    byte_wr(25'd0, 8'h05);
    check("mod_first", 64'(mod_id), 64'h05);
    ioctl_index = 8'd0;
    byte_wr(25'd1, 8'h07);
    check("mod_addr1_ignored", 64'(mod_id), 64'h05);
    byte_wr(25'd0, 8'h09);
    check("mod_index_latched", 64'(mod_id), 64'h09);
    check("mod_no_dn_wr", 64'(dn_wr), 64'd0);
    check("mod_core_reset", 64'(core_reset), 64'd0);
    ioctl_download = 1'b0;
    step();

    // 6. Reset in the middle of a ROM download
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    step();
    byte_wr(25'h0100, 8'h99);
    check("mid_pre_dn_wr", 64'(dn_wr), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_dn_addr", 64'(dn_addr), 64'd0);
    check("mid_rst_dn_data", 64'(dn_data), 64'd0);
    check("mid_rst_sw", sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mid_rst_mod_id", 64'(mod_id), 64'd0);
    check("mid_rst_overflow", 64'(addr_overflow), 64'd0);
    check("mid_rst_core_reset", 64'(core_reset), 64'd1);
    for (int i = 0; i < 4; i++) begin
      byte_wr(25'h0200 + 25'(i), 8'hA0 + 8'(i));
      check("mid_skip_dn_wr", 64'(dn_wr), 64'd0);
    end
    ioctl_download = 1'b0;
    step();
    check("mid_dn_wr_count", 64'(dn_wr_count), 64'd3);
    ioctl_download = 1'b1;
    step();
    // Last strobe lands in the same cycle as the download falling
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h0301;
    ioctl_dout     = 8'h5A;
    ioctl_download = 1'b0;
    step();
    ioctl_wr = 1'b0;
    $display("wr idx=%0d addr=%h data=%h (with fall) -> dn_wr=%b dn_addr=%h dn_data=%h",
             ioctl_index, 25'h0301, 8'h5A, dn_wr, dn_addr, dn_data);
    check("fall_dn_wr", 64'(dn_wr), 64'd1);
    check("fall_dn_addr", 64'(dn_addr), 64'h0301);
    check("fall_dn_data", 64'(dn_data), 64'h5A);
    count_reset_high(n);
    check("fall_hold_len", 64'(n), 64'd32);
    check("fall_rom_loaded", 64'(rom_loaded), 64'd1);
    check("fall_dn_wr_count", 64'(dn_wr_count), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
